// File: rtl/nand_adder_pkg.sv
// Shared constants and types for the NAND2-only ripple adder.
package nand_adder_pkg;
  localparam int ADDER_W     = 4;
  localparam int NAND_PER_FA = 9;

  typedef logic [ADDER_W-1:0] adder_word_t;
endpackage

// File: rtl/nand2_cell.sv
// Single 2-input NAND gate; the only primitive used in the adder datapath.
module nand2_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// File: rtl/nand2_full_adder.sv
// One-bit full adder built from nine NAND2 cells (p = x^y, s = p^c, co = x&y | p&c).
module nand2_full_adder
  import nand_adder_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);
  // g[0]=n1 g[1]=n2 g[2]=n3 g[3]=p g[4]=n5 g[5]=n6 g[6]=n7 g[7]=s g[8]=co
  logic [NAND_PER_FA-1:0] g;

  nand2_cell u_n1 (.a(x),    .b(y),    .y(g[0]));
  nand2_cell u_n2 (.a(x),    .b(g[0]), .y(g[1]));
  nand2_cell u_n3 (.a(y),    .b(g[0]), .y(g[2]));
  nand2_cell u_p  (.a(g[1]), .b(g[2]), .y(g[3]));
  nand2_cell u_n5 (.a(g[3]), .b(c),    .y(g[4]));
  nand2_cell u_n6 (.a(g[3]), .b(g[4]), .y(g[5]));
  nand2_cell u_n7 (.a(c),    .b(g[4]), .y(g[6]));
  nand2_cell u_s  (.a(g[5]), .b(g[6]), .y(g[7]));
  // Carry reuses n1 (~(x&y)) and n5 (~(p&c)).
  nand2_cell u_co (.a(g[4]), .b(g[0]), .y(g[8]));

  assign s  = g[7];
  assign co = g[8];
endmodule

// File: rtl/nand2_ripple_adder4.sv
// 4-bit registered ripple-carry adder from NAND2 full adders, 1-cycle latency.
// Define NAND_ADDER_OVF_EN to add the registered two's-complement ovf output.
module nand2_ripple_adder4
  import nand_adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  adder_word_t a,
  input  adder_word_t b,
  input  logic        cin,
  output logic        out_valid,
  output adder_word_t sum,
  output logic        cout
`ifdef NAND_ADDER_OVF_EN
  ,
  output logic        ovf
`endif
);
  logic [ADDER_W:0] carry;
  adder_word_t      s_w;

  assign carry[0] = cin;

  for (genvar i = 0; i < ADDER_W; i++) begin : gen_fa
    nand2_full_adder u_fa (
      .x (a[i]),
      .y (b[i]),
      .c (carry[i]),
      .s (s_w[i]),
      .co(carry[i+1])
    );
  end

  logic        out_valid_d, out_valid_q;
  adder_word_t sum_d, sum_q;
  logic        cout_d, cout_q;

`ifdef NAND_ADDER_OVF_EN
  // Overflow = carry into MSB xor carry out of MSB, as a 4-NAND XOR.
  logic ov_n1, ov_n2, ov_n3, ovf_w;
  logic ovf_d, ovf_q;

  nand2_cell u_ov_n1 (.a(carry[ADDER_W]),   .b(carry[ADDER_W-1]), .y(ov_n1));
  nand2_cell u_ov_n2 (.a(carry[ADDER_W]),   .b(ov_n1),            .y(ov_n2));
  nand2_cell u_ov_n3 (.a(carry[ADDER_W-1]), .b(ov_n1),            .y(ov_n3));
  nand2_cell u_ov_x  (.a(ov_n2),            .b(ov_n3),            .y(ovf_w));
`endif

  // Idle cycles keep the previous result so X on idle operands never reaches the flops.
  always_comb begin
    out_valid_d = 1'b0;
    sum_d       = sum_q;
    cout_d      = cout_q;
`ifdef NAND_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (in_valid) begin
      out_valid_d = 1'b1;
      sum_d       = s_w;
      cout_d      = carry[ADDER_W];
`ifdef NAND_ADDER_OVF_EN
      ovf_d       = ovf_w;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
`ifdef NAND_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
`ifdef NAND_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NAND_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_nand2_ripple_adder4.sv
// Directed-vector bench for nand2_ripple_adder4: table, exhaustive sweep, hold and reset.
module tb_nand2_ripple_adder4;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;
  logic       cin;
  logic       out_valid;
  logic [3:0] sum;
  logic       cout;
`ifdef NAND_ADDER_OVF_EN
  logic       ovf;
`endif

  always #5 clk = ~clk;

  nand2_ripple_adder4 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .sum      (sum),
    .cout     (cout)
`ifdef NAND_ADDER_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [3:0] s,
                         input logic c, input logic o);
    chk({nm, ".valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({nm, ".sum"},   {4'd0, sum},       {4'd0, s});
    chk({nm, ".cout"},  {7'd0, cout},      {7'd0, c});
`ifdef NAND_ADDER_OVF_EN
    chk({nm, ".ovf"},   {7'd0, ovf},       {7'd0, o});
`else
    if (o === 1'bx) $display("unused");
`endif
  endtask

  vec_t tbl[10];

  initial begin
    logic [4:0] ref5;
    logic       ref_ovf;
    logic [3:0] held_sum;
    logic       held_cout, held_ovf;

    tbl[0] = '{4'hA, 4'hB, 1'b0, 4'h5, 1'b1, 1'b1};
    tbl[1] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
    tbl[2] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[3] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    tbl[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
    tbl[5] = '{4'h3, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0};
    tbl[6] = '{4'h5, 4'h6, 1'b1, 4'hC, 1'b0, 1'b1};
    tbl[7] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    tbl[8] = '{4'h9, 4'h6, 1'b0, 4'hF, 1'b0, 1'b0};
    tbl[9] = '{4'hC, 4'h5, 1'b0, 4'h1, 1'b1, 1'b0};

    // Reset for two cycles
    rst = 1'b1; in_valid = 1'b0; a = 4'h0; b = 4'h0; cin = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed table, back-to-back
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = tbl[i].a; b = tbl[i].b; cin = tbl[i].cin;
      tick();
      chk_out($sformatf("tbl%0d", i), 1'b1, tbl[i].exp_sum, tbl[i].exp_cout, tbl[i].exp_ovf);
    end

    // Exhaustive sweep with in_valid held high
    for (int i = 0; i < 512; i++) begin
      a = i[8:5]; b = i[4:1]; cin = i[0];
      ref5    = {1'b0, a} + {1'b0, b} + {4'd0, cin};
      ref_ovf = (a[3] == b[3]) && (ref5[3] != a[3]);
      tick();
      chk_out($sformatf("sweep%0d", i), 1'b1, ref5[3:0], ref5[4], ref_ovf);
    end
    held_sum = 4'hF; held_cout = 1'b1; held_ovf = 1'b0;  // last sweep: F+F+1

    // Idle cycles with junk operands: outputs hold, valid drops
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); cin = 1'($urandom_range(0, 1));
      tick();
      chk_out($sformatf("hold%0d", i), 1'b0, held_sum, held_cout, held_ovf);
    end
    in_valid = 1'b0; a = 4'bxxxx; b = 4'bxxxx; cin = 1'bx;
    tick();
    chk_out("hold_x", 1'b0, held_sum, held_cout, held_ovf);

    // Reset mid-stream: valid operands in the reset cycle are discarded
    in_valid = 1'b1; a = 4'h7; b = 4'h1; cin = 1'b0;
    tick();
    chk_out("pre_rst", 1'b1, 4'h8, 1'b0, 1'b1);
    rst = 1'b1; a = 4'hA; b = 4'hB;
    tick();
    chk_out("mid_rst", 1'b0, 4'h0, 1'b0, 1'b0);
    // First in_valid sampled with rst low produces the first result
    rst = 1'b0; a = 4'h8; b = 4'h8; cin = 1'b0;
    tick();
    chk_out("post_rst", 1'b1, 4'h0, 1'b1, 1'b1);
    in_valid = 1'b0;
    tick();
    chk_out("post_idle", 1'b0, 4'h0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
